// File: rtl/seq_tx_pkg.sv
// Shared definitions for the seq_tx serial frame transmitter: state encoding,
// sync pattern and a sizing helper for the bit counter.
package seq_tx_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSync   = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StGap    = 3'd4
    } state_e;

    localparam logic [3:0]  SYNC_PATTERN = 4'b0110;
    localparam int unsigned SYNC_LEN     = 4;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seq_tx_shifter.sv
// Payload shift register for seq_tx: captures a word on load, presents its MSB
// on serial_out and shifts left on shift_en; parity is latched with the word.
module seq_tx_shifter #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift_en,
    input  logic [DATA_W-1:0] load_data,
    output logic              serial_out,
    output logic              parity_out
);

    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic              parity_q, parity_d;

    always_comb begin
        sreg_d   = sreg_q;
        parity_d = parity_q;
        if (load) begin
            sreg_d   = load_data;
            parity_d = ^load_data;
        end else if (shift_en) begin
            sreg_d = sreg_q << 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_q   <= '0;
            parity_q <= 1'b0;
        end else begin
            sreg_q   <= sreg_d;
            parity_q <= parity_d;
        end
    end

    assign serial_out = sreg_q[DATA_W-1];
    assign parity_out = parity_q;

endmodule

// File: rtl/seq_tx.sv
// Framed serial transmitter: sync pattern, MSB-first payload, optional even
// parity and an idle-high gap, driven from a registered line output.
module seq_tx
    import seq_tx_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned PARITY_EN = 1,
    parameter int unsigned IDLE_GAP  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              dout_bit,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned CntMax = max3(SYNC_LEN, DATA_W, IDLE_GAP);
    localparam int unsigned CntW   = $clog2(CntMax);

    typedef logic [CntW-1:0] cnt_t;

    localparam cnt_t SyncLast = cnt_t'(SYNC_LEN - 1);
    localparam cnt_t DataLast = cnt_t'(DATA_W - 1);
    localparam cnt_t GapLast  = cnt_t'(IDLE_GAP - 1);

    // state_q/cnt_q name the bit the next edge drives onto the line, so the
    // last gap bit is already on the wire while the block sits in StIdle.
    state_e state_q, state_d;
    cnt_t   cnt_q, cnt_d;
    logic   dout_q, dout_d;
    logic   done_q, done_d;
    logic   ready_q, ready_d;

    logic accept;
    logic load;
    logic shift_en;
    logic serial_out;
    logic parity_out;

    assign accept = in_valid & ready_q;

    seq_tx_shifter #(
        .DATA_W(DATA_W)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .shift_en  (shift_en),
        .load_data (in_data),
        .serial_out(serial_out),
        .parity_out(parity_out)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dout_d   = 1'b1;
        done_d   = 1'b0;
        load     = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    load    = 1'b1;
                    dout_d  = SYNC_PATTERN[SYNC_LEN-1];
                    state_d = StSync;
                    cnt_d   = cnt_t'(1);
                end
            end
            StSync: begin
                // ~cnt maps sync bit 1..3 onto pattern index 2..0
                dout_d = SYNC_PATTERN[~cnt_q[1:0]];
                if (cnt_q == SyncLast) begin
                    state_d = StData;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            StData: begin
                dout_d   = serial_out;
                shift_en = 1'b1;
                if (cnt_q == DataLast) begin
                    state_d = (PARITY_EN != 0) ? StParity : StGap;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            StParity: begin
                dout_d  = parity_out;
                state_d = StGap;
                cnt_d   = '0;
            end
            StGap: begin
                done_d = (cnt_q == '0);
                if (cnt_q == GapLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign ready_d = (state_d == StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dout_q  <= 1'b1;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign in_ready   = ready_q;
    assign dout_bit   = dout_q;
    assign busy       = (state_q != StIdle);
    assign frame_done = done_q;

endmodule

// File: doc/seq_tx.md
SEQ_TX -- requirements
Module: seq_tx

Interface
REQ-001 Parameter DATA_W, default 8: payload bits per frame (legal range 1..16).
REQ-002 Parameter PARITY_EN, default 1: 1 appends an even-parity bit after the payload; 0 omits it.
REQ-003 Parameter IDLE_GAP, default 2: minimum idle-high bit times between frames (legal range 1..15).
REQ-004 clk  input  1  Sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  Reset; asynchronous, active-high.
REQ-006 in_valid  input  1  Payload offered this cycle.
REQ-007 in_data  input  DATA_W  Payload word, transmitted MSB first.
REQ-008 in_ready  output  1  Block can accept a payload this cycle.
REQ-009 dout_bit  output  1  Registered serial line output; idles at 1.
REQ-010 busy  output  1  High whenever state is not IDLE.
REQ-011 frame_done  output  1  One-cycle pulse marking frame completion.

Function
REQ-012 The block SHALL emit frames in this order: sync pattern 0,1,1,0; DATA_W payload bits, MSB first; one parity bit if PARITY_EN=1; then IDLE_GAP bits of 1.
REQ-013 The FSM SHALL have the states IDLE, SYNC, DATA, PARITY and GAP, with a single bit counter sized for max(4, DATA_W, IDLE_GAP).
REQ-014 in_ready SHALL be 1 only in IDLE, decoded from the registered state.
REQ-015 A handshake is accepted at the rising edge where in_valid=1 and in_ready=1; in_data SHALL be latched on that edge, and later changes to in_data SHALL have no effect on the current frame.
REQ-016 Latency: sync bit 0 SHALL appear on dout_bit in the cycle immediately after the accepting edge; each subsequent bit SHALL last exactly one cycle.
REQ-017 Transitions: IDLE->SYNC on accept; SYNC->DATA after 4 bits; DATA->PARITY after DATA_W bits if PARITY_EN=1, otherwise DATA->GAP; PARITY->GAP after 1 bit; GAP->IDLE after IDLE_GAP bits.
REQ-018 The parity bit SHALL equal the XOR of the latched payload bits, so that payload plus parity has an even number of ones.
REQ-019 dout_bit SHALL be 1 in IDLE and GAP.
REQ-020 frame_done SHALL pulse high for exactly one cycle, coincident with the first GAP bit.
REQ-021 When in_valid is held high, the next accept SHALL occur on the first IDLE cycle, so that back-to-back frames are separated by exactly IDLE_GAP high bits.
REQ-022 in_valid with in_ready=0 SHALL be ignored with no side effects, and the payload SHALL remain offered until accepted.
REQ-023 Any unused or illegal state encoding SHALL return to IDLE on the next edge.

Reset
REQ-024 While rst=1: state=IDLE, dout_bit=1, in_ready=0, busy=0, frame_done=0, counter=0, payload register=0.
REQ-025 Assertion of rst mid-frame SHALL abort the frame immediately (asynchronously): no further bits are sent and no frame_done pulse is generated.
REQ-026 in_ready SHALL rise in the first cycle after rst deasserts.

Structure
REQ-027 The shared package seq_tx_pkg SHALL hold the state encoding constants, SYNC_PATTERN=4'b0110 and SYNC_LEN=4.
REQ-028 The payload and parity shifting SHALL be implemented in one sub-module, seq_tx_shifter (load, shift_en, serial_out, parity_out); the FSM and counter stay in seq_tx.

Verification
REQ-029 Defaults, single accept of 0xA5 -> dout_bit sequence 0110 10100101 0 11, then IDLE; frame_done one cycle at the first 1 after parity; 13 busy bit times plus 2 gap bits.
REQ-030 Payloads 0x01 and 0xFF -> parity bits 1 and 0 respectively; with PARITY_EN=0 and 0x01 -> 0110 00000001 11, no parity bit.
REQ-031 in_valid held high with payloads 0x3C then 0xC3 -> second sync 0 appears exactly 2 high bits after the first frame's parity bit; in_ready low throughout each frame.
REQ-032 in_data changed every cycle after accepting 0x5A -> line still carries 01011010 and parity 0.
REQ-033 rst pulsed during payload bit 3 -> dout_bit=1 and busy=0 immediately; no frame_done; in_ready=1 in the first cycle after release; a new 0x0F frame then transmits correctly.
REQ-034 Forced illegal state via the bench -> IDLE on the next edge with dout_bit=1; over a random 1000-frame run, a scoreboard rebuilds every payload from dout_bit with zero mismatches.
